// File: rtl/hack_pkg.sv
// Shared definitions for the Hack clock receive-side logic.
package hack_pkg;

  // Default width of the half-period counter and measurement.
  localparam int HACK_CNT_W = 7;

  // Lock state of the monitored Hack clock.
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } hack_state_e;

endpackage

// File: rtl/hack_sync_edge.sv
// Two-flop synchroniser plus history flop for an asynchronous Hack-side
// level.  Rise/fall outputs are combinational one-cycle pulses derived from
// the synchronised level and its history; callers register them as needed.
module hack_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Metastability chain (s1, s2) followed by the history flop (s3).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_sync = r_s3;
  assign o_rise = r_s2 & ~r_s3;
  assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/hack_clock_monitor.sv
// Receive-side Hack clock monitor: synchronises an external slow clock,
// measures its half-period in clk cycles, locks onto a stable period and
// regenerates rise/fall strobes plus an early "going to rise" warning.
module hack_clock_monitor
  import hack_pkg::*;
#(
  parameter int CNT_W      = HACK_CNT_W,
  parameter int EARLY      = 2,
  parameter int TOL        = 1,
  parameter int LOCK_COUNT = 2,
  parameter int TIMEOUT    = 127
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hack_clk_in,
  output logic             hack_clk_sync,
  output logic             rise_strobe,
  output logic             fall_strobe,
  output logic             going_to_rise,
  output logic             locked,
  output logic [CNT_W-1:0] half_period,
  output logic             timeout_err
);

  localparam int MC_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] TMO_V   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   EARLY_V = (CNT_W + 1)'(EARLY);
  localparam logic [CNT_W:0]   TOL_V   = (CNT_W + 1)'(TOL);
  localparam logic [MC_W-1:0]  LC_V    = MC_W'(LOCK_COUNT);

  // Distance between two half-period values, one bit wider so it never wraps.
  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    if (a >= b) abs_diff = {1'b0, a} - {1'b0, b};
    else        abs_diff = {1'b0, b} - {1'b0, a};
  endfunction

  // Internal reset: asserts with reset_n, releases two clk edges later.
  logic r_rst_meta;
  logic r_rst_sync;
  logic w_rst_n;

  // Reset synchroniser so deassertion is always aligned to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = reset_n & r_rst_sync;

  // Synchronised Hack clock and its raw edge pulses.
  logic w_sync;
  logic w_rise;
  logic w_fall;
  logic w_edge;

  hack_sync_edge u_sync_edge (
    .i_clk   (clk),
    .i_rst_n (w_rst_n),
    .i_async (hack_clk_in),
    .o_sync  (w_sync),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_edge = w_rise | w_fall;

  // Measurement datapath state.
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_half;
  logic             r_rise;
  logic             r_fall;
  logic             r_tmo;

  // Lock FSM state.
  hack_state_e      r_state;
  hack_state_e      w_state_nx;
  logic [CNT_W-1:0] r_ref;
  logic [CNT_W-1:0] w_ref_nx;
  logic [MC_W-1:0]  r_mcnt;
  logic [MC_W-1:0]  w_mcnt_nx;
  logic             r_armed;
  logic             w_armed_nx;

  logic             w_cnt_sat;
  logic [CNT_W-1:0] w_meas;
  logic             w_match;
  logic             w_tmo_hit;
  logic [MC_W-1:0]  w_mcnt_inc;
  logic             w_g2r;

  // The measurement includes the edge cycle itself, so a steady period of
  // 2*P clk cycles measures exactly P; it saturates with the counter.
  assign w_cnt_sat  = (r_cnt >= TMO_V);
  assign w_meas     = w_cnt_sat ? TMO_V : (r_cnt + CNT_W'(1));
  assign w_match    = (abs_diff(w_meas, r_ref) <= TOL_V);
  assign w_mcnt_inc = r_mcnt + MC_W'(1);

  // Fires only on the step into saturation, so a dead clock reports once;
  // a coincident edge restarts the counter and suppresses the report.
  assign w_tmo_hit  = !w_edge && !w_cnt_sat && (w_meas == TMO_V);

  // Half-period counter, measurement capture and registered strobes.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt  <= '0;
      r_half <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_tmo  <= 1'b0;
    end else begin
      r_rise <= w_rise;
      r_fall <= w_fall;
      r_tmo  <= w_tmo_hit;
      if (w_edge) begin
        r_half <= w_meas;
        r_cnt  <= '0;
      end else if (!w_cnt_sat) begin
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Lock FSM next-state: evaluated on each detected edge or on timeout.
  always_comb begin
    w_state_nx = r_state;
    w_ref_nx   = r_ref;
    w_mcnt_nx  = r_mcnt;
    w_armed_nx = r_armed;
    if (w_edge) begin
      unique case (r_state)
        UNLOCKED: begin
          // The first edge after reset/timeout only starts the counter;
          // the span before it is not a real half-period.
          if (!r_armed) begin
            w_armed_nx = 1'b1;
          end else begin
            w_ref_nx   = w_meas;
            w_mcnt_nx  = '0;
            w_state_nx = LOCKING;
          end
        end
        LOCKING: begin
          if (w_match) begin
            w_mcnt_nx = w_mcnt_inc;
            if (w_mcnt_inc >= LC_V) w_state_nx = LOCKED;
          end else begin
            w_ref_nx  = w_meas;
            w_mcnt_nx = '0;
          end
        end
        LOCKED: begin
          if (!w_match) begin
            w_ref_nx   = w_meas;
            w_mcnt_nx  = '0;
            w_state_nx = LOCKING;
          end
        end
        default: begin
          w_state_nx = UNLOCKED;
          w_armed_nx = 1'b0;
          w_mcnt_nx  = '0;
        end
      endcase
    end else if (w_tmo_hit) begin
      w_state_nx = UNLOCKED;
      w_armed_nx = 1'b0;
      w_mcnt_nx  = '0;
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= UNLOCKED;
      r_ref   <= '0;
      r_mcnt  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ref   <= w_ref_nx;
      r_mcnt  <= w_mcnt_nx;
      r_armed <= w_armed_nx;
    end
  end

  // Warn EARLY cycles ahead of the predicted rise; the counter value seen in
  // the rise_strobe cycle is 0, so the prediction point is half_period-EARLY.
  // With half_period <= EARLY there is no room for a warning.
  assign w_g2r = (r_state == LOCKED) && !w_sync &&
                 ({1'b0, r_half} > EARLY_V) &&
                 (({1'b0, r_cnt} + EARLY_V) == {1'b0, r_half});

  assign hack_clk_sync = w_sync;
  assign rise_strobe   = r_rise;
  assign fall_strobe   = r_fall;
  assign going_to_rise = w_g2r;
  assign locked        = (r_state == LOCKED);
  assign half_period   = r_half;
  assign timeout_err   = r_tmo;

endmodule

// File: tb/tb_hack_clock_monitor.sv
// Directed bench for hack_clock_monitor: the stimulus process toggles the
// Hack clock and queues the hand-computed response for each edge; a monitor
// process pops and compares whenever a strobe or timeout appears.
module tb_hack_clock_monitor;

  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             hack_clk_in;
  logic             hack_clk_sync;
  logic             rise_strobe;
  logic             fall_strobe;
  logic             going_to_rise;
  logic             locked;
  logic [CNT_W-1:0] half_period;
  logic             timeout_err;

  hack_clock_monitor #(
    .CNT_W      (CNT_W),
    .EARLY      (2),
    .TOL        (1),
    .LOCK_COUNT (2),
    .TIMEOUT    (127)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .hack_clk_in   (hack_clk_in),
    .hack_clk_sync (hack_clk_sync),
    .rise_strobe   (rise_strobe),
    .fall_strobe   (fall_strobe),
    .going_to_rise (going_to_rise),
    .locked        (locked),
    .half_period   (half_period),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  // mode (rises only): 0 = no warning since previous strobe,
  // 1 = exactly one warning, two cycles before the rise, 2 = not checked.
  typedef struct {
    bit rise;
    int hp;
    bit chk_hp;
    bit lk;
    int mode;
  } exp_t;

  exp_t exp_q[$];
  int   tmo_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   tmo_seen = 0;
  int   n_edges  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string name);
    chk(name, int'({hack_clk_sync, rise_strobe, fall_strobe, going_to_rise,
                    locked, timeout_err, half_period}), 0);
  endtask

  // Wait n clk cycles, toggle the Hack clock and queue the expected response.
  task automatic edge_after(input int n, input int hp, input bit chk_hp,
                            input bit lk, input int mode);
    exp_t e;
    repeat (n) @(negedge clk);
    hack_clk_in = ~hack_clk_in;
    e.rise   = hack_clk_in;
    e.hp     = hp;
    e.chk_hp = chk_hp;
    e.lk     = lk;
    e.mode   = mode;
    exp_q.push_back(e);
  endtask

  // Eight edges 35 cycles apart starting from a fresh reset.
  task automatic steady35();
    edge_after(35,  0, 0, 0, 0);  // rise: seeds the counter only
    edge_after(35, 35, 1, 0, 2);  // fall: reference set
    edge_after(35, 35, 1, 0, 0);  // rise: first match
    edge_after(35, 35, 1, 1, 2);  // fall: second match, locked
    edge_after(35, 35, 1, 1, 1);
    edge_after(35, 35, 1, 1, 2);
    edge_after(35, 35, 1, 1, 1);
    edge_after(35, 35, 1, 1, 2);
  endtask

  // Monitor: compares every strobe and timeout pulse against the queues.
  initial begin : monitor
    exp_t e;
    int   cyc;
    int   g2r_cnt;
    bit   d1;
    bit   d2;
    bit   lk_d1;
    int   exp_lk;
    cyc = 0; g2r_cnt = 0; d1 = 1'b0; d2 = 1'b0; lk_d1 = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cyc = 0; g2r_cnt = 0; d1 = 1'b0; d2 = 1'b0; lk_d1 = 1'b0;
      end else begin
        if (rise_strobe || fall_strobe) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_strobe", int'({rise_strobe, fall_strobe}), 0);
          end else begin
            e = exp_q.pop_front();
            n_edges++;
            chk("strobe_kind", int'({rise_strobe, fall_strobe}), e.rise ? 2 : 1);
            if (e.chk_hp) chk("half_period", int'(half_period), e.hp);
            chk("locked_at_edge", int'(locked), int'(e.lk));
            if (!e.rise)
              chk("g2r_before_fall", g2r_cnt, 0);
            else if (e.mode != 2)
              chk("g2r_count_x2_plus_lag2", g2r_cnt * 2 + int'(d2), e.mode * 3);
          end
          cyc = 0;
          g2r_cnt = 0;
        end else begin
          cyc++;
          if (going_to_rise) g2r_cnt++;
        end
        if (timeout_err) begin
          tmo_seen++;
          if (tmo_q.size() == 0) begin
            chk("unexpected_timeout", 1, 0);
          end else begin
            exp_lk = tmo_q.pop_front();
            chk("timeout_gap", cyc, 127);
            chk("timeout_locked", int'(locked), 0);
            chk("locked_before_timeout", int'(lk_d1), exp_lk);
          end
        end
        d2 = d1;
        d1 = going_to_rise;
        lk_d1 = locked;
      end
    end
  end

  // Stimulus.
  initial begin : stimulus
    reset_n     = 1'b0;
    hack_clk_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset_outputs");
    @(negedge clk);
    reset_n = 1'b1;

    // Steady 35-cycle half-periods from reset.
    steady35();

    // Jitter within tolerance keeps lock.
    edge_after(35, 35, 1, 1, 1);
    edge_after(36, 36, 1, 1, 2);
    edge_after(35, 35, 1, 1, 2);
    edge_after(36, 36, 1, 1, 2);
    edge_after(35, 35, 1, 1, 2);
    edge_after(36, 36, 1, 1, 2);
    // A 40 breaks lock; two more 40s relock.
    edge_after(40, 40, 1, 0, 2);
    edge_after(40, 40, 1, 0, 2);
    edge_after(40, 40, 1, 1, 0);
    edge_after(40, 40, 1, 1, 2);
    edge_after(40, 40, 1, 1, 1);
    edge_after(40, 40, 1, 1, 2);

    // Clock stops: one timeout, then reacquisition.
    tmo_q.push_back(1);
    edge_after(300, 127, 1, 0, 2);
    edge_after(35, 35, 1, 0, 2);
    edge_after(35, 35, 1, 0, 0);
    edge_after(35, 35, 1, 1, 2);
    edge_after(35, 35, 1, 1, 1);
    edge_after(35, 35, 1, 1, 2);

    // Half-period 2: locks, but too short for any early warning.
    edge_after(2, 2, 1, 0, 0);
    edge_after(2, 2, 1, 0, 2);
    edge_after(2, 2, 1, 1, 0);
    edge_after(2, 2, 1, 1, 2);
    edge_after(2, 2, 1, 1, 0);
    edge_after(2, 2, 1, 1, 2);
    edge_after(2, 2, 1, 1, 0);
    edge_after(2, 2, 1, 1, 2);
    edge_after(2, 2, 1, 1, 0);
    edge_after(2, 2, 1, 1, 2);

    // Back to 35 and lock before the mid-run reset.
    edge_after(35, 35, 1, 0, 0);
    edge_after(35, 35, 1, 0, 2);
    edge_after(35, 35, 1, 1, 0);
    edge_after(35, 35, 1, 1, 2);
    repeat (17) @(negedge clk);
    chk("queue_drained_before_reset", exp_q.size(), 0);
    chk("locked_before_reset", int'(locked), 1);

    // Asynchronous reset between clk edges.
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("async_reset_outputs");
    hack_clk_in = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    steady35();
    repeat (10) @(negedge clk);

    chk("all_expected_edges_seen", exp_q.size(), 0);
    chk("edges_seen", n_edges, 48);
    chk("timeout_pulses", tmo_seen, 1);
    chk("timeout_queue_drained", tmo_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
